// File: rtl/m_of_n_pkg.sv
// Shared types and width helpers for the serial M-of-N codeword checker.
package m_of_n_pkg;

   // Receive FSM: nothing held, partial word within weight, partial word already over weight
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RECV = 2'd1,
      S_OVER = 2'd2
   } state_t;

   // Width of the bit position counter (counts 0..n-1)
   function automatic int bit_cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Width of the ones counter (must hold values up to n)
   function automatic int ones_cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/serial_m_of_n_checker_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_l,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   // Count enabled events, sticking at the all-ones value
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         count_reg <= '0;
      end else if (en && (count_reg != {W{1'b1}})) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/serial_m_of_n_checker.sv
// Serial M-of-N constant-weight codeword checker with bit strobe, frame
// resync, early over-weight detection, captured word and error counter.
module serial_m_of_n_checker
   import m_of_n_pkg::*;
#(
   parameter int N         = 5,
   parameter int M         = 2,
   parameter bit LSB_FIRST = 1'b1,
   parameter int ERR_W     = 8
) (
   input  logic             clk,
   input  logic             reset_l,
   input  logic             in,
   input  logic             in_valid,
   input  logic             sync,
   output logic             valid,
   output logic             invalid,
   output logic [N-1:0]     word,
   output logic             word_valid,
   output logic [ERR_W-1:0] err_count,
   output logic             busy
);

   localparam int BW = bit_cnt_w(N);
   localparam int OW = ones_cnt_w(N);

   // Constants sized to their comparison partners
   localparam logic [BW-1:0] LAST_IDX = BW'(N - 1);
   localparam logic [OW:0]   M_EXT    = (OW + 1)'(M);
   localparam logic [OW:0]   M_SAT    = (OW + 1)'(M + 1);

   generate
      if (N < 2 || M < 1 || M > N || ERR_W < 1) begin : g_bad_params
         $error("serial_m_of_n_checker: illegal parameters (need N>=2, 1<=M<=N, ERR_W>=1)");
      end
   endgenerate

   state_t        state_reg, state_next;
   logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
   logic [OW-1:0] ones_cnt_reg, ones_cnt_next;
   logic [N-1:0]  sh_reg, sh_next;
   logic [N-1:0]  word_reg, word_next;
   logic          word_valid_reg, word_valid_next;
   logic          busy_reg;

   logic [N-1:0]  sh_shifted;
   logic [OW:0]   eff_cnt;
   logic [OW:0]   eff_sat;

   // Shift direction decides where the first received bit ends up
   generate
      if (LSB_FIRST) begin : g_lsb_first
         assign sh_shifted = {in, sh_reg[N-1:1]};
      end else begin : g_msb_first
         assign sh_shifted = {sh_reg[N-2:0], in};
      end
   endgenerate

   // Weight including the bit on the wire, clamped at M+1 (already invalid)
   assign eff_cnt = {1'b0, ones_cnt_reg} + (OW + 1)'(in);
   assign eff_sat = (eff_cnt > M_EXT) ? M_SAT : eff_cnt;

   // Next-state, datapath updates and Mealy verdict outputs
   always_comb begin
      state_next      = state_reg;
      bit_cnt_next    = bit_cnt_reg;
      ones_cnt_next   = ones_cnt_reg;
      sh_next         = sh_reg;
      word_next       = word_reg;
      word_valid_next = 1'b0;
      valid           = 1'b0;
      invalid         = 1'b0;

      if (in_valid) begin
         if (sync || state_reg == S_IDLE) begin
            // Start of a new frame; any partial word is dropped silently
            state_next    = S_RECV;
            bit_cnt_next  = BW'(1);
            ones_cnt_next = OW'(in);
            sh_next       = sh_shifted;
         end else if (bit_cnt_reg == LAST_IDX) begin
            // Final bit: deliver verdict and capture the word
            valid           = (state_reg == S_RECV) && (eff_sat == M_EXT);
            invalid         = !valid;
            sh_next         = sh_shifted;
            word_next       = sh_shifted;
            word_valid_next = 1'b1;
            state_next      = S_IDLE;
            bit_cnt_next    = '0;
            ones_cnt_next   = '0;
         end else begin
            bit_cnt_next  = bit_cnt_reg + 1'b1;
            ones_cnt_next = eff_sat[OW-1:0];
            sh_next       = sh_shifted;
            if (state_reg == S_OVER || eff_sat > M_EXT) begin
               state_next = S_OVER;
            end else begin
               state_next = S_RECV;
            end
         end
      end else if (sync) begin
         // Frame marker with no data: abandon the partial word
         state_next    = S_IDLE;
         bit_cnt_next  = '0;
         ones_cnt_next = '0;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_reg      <= S_IDLE;
         bit_cnt_reg    <= '0;
         ones_cnt_reg   <= '0;
         sh_reg         <= '0;
         word_reg       <= '0;
         word_valid_reg <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         bit_cnt_reg    <= bit_cnt_next;
         ones_cnt_reg   <= ones_cnt_next;
         sh_reg         <= sh_next;
         word_reg       <= word_next;
         word_valid_reg <= word_valid_next;
         busy_reg       <= (state_next != S_IDLE);
      end
   end

   sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .clk     (clk),
      .reset_l (reset_l),
      .en      (invalid),
      .count   (err_count)
   );

   assign word       = word_reg;
   assign word_valid = word_valid_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_serial_m_of_n_checker.sv
// Self-checking bench for serial_m_of_n_checker: table-driven default
// configuration plus directed sequences for saturation, N=8/MSB-first and reset.
module tb_serial_m_of_n_checker;

   logic clk = 1'b0;
   logic reset_l = 1'b0;

   // Instance A: defaults (N=5, M=2, LSB first, ERR_W=8)
   logic       a_in = 1'b0, a_iv = 1'b0, a_sy = 1'b0;
   logic       a_valid, a_invalid, a_wv, a_busy;
   logic [4:0] a_word;
   logic [7:0] a_err;

   // Instance B: ERR_W=2 for saturation
   logic       b_in = 1'b0, b_iv = 1'b0, b_sy = 1'b0;
   logic       b_valid, b_invalid, b_wv, b_busy;
   logic [4:0] b_word;
   logic [1:0] b_err;

   // Instance C: N=8, M=3, MSB first
   logic       c_in = 1'b0, c_iv = 1'b0, c_sy = 1'b0;
   logic       c_valid, c_invalid, c_wv, c_busy;
   logic [7:0] c_word;
   logic [7:0] c_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_m_of_n_checker u_a (
      .clk(clk), .reset_l(reset_l), .in(a_in), .in_valid(a_iv), .sync(a_sy),
      .valid(a_valid), .invalid(a_invalid), .word(a_word), .word_valid(a_wv),
      .err_count(a_err), .busy(a_busy)
   );

   serial_m_of_n_checker #(.N(5), .M(2), .LSB_FIRST(1'b1), .ERR_W(2)) u_b (
      .clk(clk), .reset_l(reset_l), .in(b_in), .in_valid(b_iv), .sync(b_sy),
      .valid(b_valid), .invalid(b_invalid), .word(b_word), .word_valid(b_wv),
      .err_count(b_err), .busy(b_busy)
   );

   serial_m_of_n_checker #(.N(8), .M(3), .LSB_FIRST(1'b0), .ERR_W(8)) u_c (
      .clk(clk), .reset_l(reset_l), .in(c_in), .in_valid(c_iv), .sync(c_sy),
      .valid(c_valid), .invalid(c_invalid), .word(c_word), .word_valid(c_wv),
      .err_count(c_err), .busy(c_busy)
   );

   typedef struct {
      logic       iv;
      logic       sy;
      logic       bit_in;
      logic       exp_v;
      logic       exp_inv;
      logic [4:0] exp_word;
      logic       exp_wv;
      logic [7:0] exp_err;
      logic       exp_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic sy, input logic b, input logic v,
                      input logic inv, input logic [4:0] w, input logic wv,
                      input logic [7:0] e, input logic bz);
      vec_t t;
      t.iv = iv; t.sy = sy; t.bit_in = b; t.exp_v = v; t.exp_inv = inv;
      t.exp_word = w; t.exp_wv = wv; t.exp_err = e; t.exp_busy = bz;
      vecs.push_back(t);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // iv sy in | v inv | word wv err busy (registered values seen before this row's edge)
      // word 1,1,0,0,0 -> valid
      add(1,0,1, 0,0, 5'b00000,0,0,0);
      add(1,0,1, 0,0, 5'b00000,0,0,1);
      add(1,0,0, 0,0, 5'b00000,0,0,1);
      add(1,0,0, 0,0, 5'b00000,0,0,1);
      add(1,0,0, 1,0, 5'b00000,0,0,1);
      // back-to-back word 1,1,1,0,0 -> over weight, invalid
      add(1,0,1, 0,0, 5'b00011,1,0,0);
      add(1,0,1, 0,0, 5'b00011,0,0,1);
      add(1,0,1, 0,0, 5'b00011,0,0,1);
      add(1,0,0, 0,0, 5'b00011,0,0,1);
      add(1,0,0, 0,1, 5'b00011,0,0,1);
      // 1,0 then resync with 0,0,1,1,0 -> valid 01100
      add(1,0,1, 0,0, 5'b00111,1,1,0);
      add(1,0,0, 0,0, 5'b00111,0,1,1);
      add(1,1,0, 0,0, 5'b00111,0,1,1);
      add(1,0,0, 0,0, 5'b00111,0,1,1);
      add(1,0,1, 0,0, 5'b00111,0,1,1);
      add(1,0,1, 0,0, 5'b00111,0,1,1);
      add(1,0,0, 1,0, 5'b00111,0,1,1);
      add(0,0,0, 0,0, 5'b01100,1,1,0);
      // 1,0, three idle cycles (in toggling, ignored), 0,0,1 -> valid 10001
      add(1,0,1, 0,0, 5'b01100,0,1,0);
      add(1,0,0, 0,0, 5'b01100,0,1,1);
      add(0,0,1, 0,0, 5'b01100,0,1,1);
      add(0,0,1, 0,0, 5'b01100,0,1,1);
      add(0,0,0, 0,0, 5'b01100,0,1,1);
      add(1,0,0, 0,0, 5'b01100,0,1,1);
      add(1,0,0, 0,0, 5'b01100,0,1,1);
      add(1,0,1, 1,0, 5'b01100,0,1,1);
      // one bit, then sync without strobe drops it
      add(1,0,1, 0,0, 5'b10001,1,1,0);
      add(0,1,0, 0,0, 5'b10001,0,1,1);
      add(0,0,0, 0,0, 5'b10001,0,1,0);
      // four bits, then sync on the would-be last bit: no verdict, new frame
      add(1,0,1, 0,0, 5'b10001,0,1,0);
      add(1,0,1, 0,0, 5'b10001,0,1,1);
      add(1,0,0, 0,0, 5'b10001,0,1,1);
      add(1,0,0, 0,0, 5'b10001,0,1,1);
      add(1,1,1, 0,0, 5'b10001,0,1,1);
      add(0,0,0, 0,0, 5'b10001,0,1,1);

      // Reset behaviour, with a strobed bit present that must be ignored
      a_iv = 1'b1; a_in = 1'b1;
      step();
      step();
      chk("reset valid",    {31'd0, a_valid},   32'd0);
      chk("reset invalid",  {31'd0, a_invalid}, 32'd0);
      chk("reset word",     {27'd0, a_word},    32'd0);
      chk("reset wv",       {31'd0, a_wv},      32'd0);
      chk("reset err",      {24'd0, a_err},     32'd0);
      chk("reset busy",     {31'd0, a_busy},    32'd0);
      a_iv = 1'b0; a_in = 1'b0;
      reset_l = 1'b1;

      // Table-driven run on instance A
      for (int i = 0; i < vecs.size(); i++) begin
         step();
         a_iv = vecs[i].iv; a_sy = vecs[i].sy; a_in = vecs[i].bit_in;
         @(negedge clk);
         chk($sformatf("row%0d valid", i),   {31'd0, a_valid},   {31'd0, vecs[i].exp_v});
         chk($sformatf("row%0d invalid", i), {31'd0, a_invalid}, {31'd0, vecs[i].exp_inv});
         chk($sformatf("row%0d word", i),    {27'd0, a_word},    {27'd0, vecs[i].exp_word});
         chk($sformatf("row%0d wv", i),      {31'd0, a_wv},      {31'd0, vecs[i].exp_wv});
         chk($sformatf("row%0d err", i),     {24'd0, a_err},     {24'd0, vecs[i].exp_err});
         chk($sformatf("row%0d busy", i),    {31'd0, a_busy},    {31'd0, vecs[i].exp_busy});
         $display("[TB] A row %0d iv=%0b sy=%0b in=%0b v=%0b inv=%0b word=%b err=%0d",
                  i, vecs[i].iv, vecs[i].sy, vecs[i].bit_in, a_valid, a_invalid, a_word, a_err);
      end
      step();
      a_iv = 1'b0; a_sy = 1'b0; a_in = 1'b0;

      // Instance B: four all-zero words, error counter saturates at 3
      for (int k = 0; k < 4; k++) begin
         for (int b = 0; b < 5; b++) begin
            b_iv = 1'b1; b_in = 1'b0;
            @(negedge clk);
            chk($sformatf("B w%0d b%0d invalid", k, b), {31'd0, b_invalid}, (b == 4) ? 32'd1 : 32'd0);
            chk($sformatf("B w%0d b%0d valid", k, b),   {31'd0, b_valid},   32'd0);
            if (b == 0 && k > 0) begin
               chk($sformatf("B w%0d err", k),  {30'd0, b_err}, k);
               chk($sformatf("B w%0d word", k), {27'd0, b_word}, 32'd0);
               chk($sformatf("B w%0d wv", k),   {31'd0, b_wv},  32'd1);
            end
            step();
         end
         $display("[TB] B word %0d done err=%0d", k, b_err);
      end
      b_iv = 1'b0;
      @(negedge clk);
      chk("B final err", {30'd0, b_err}, 32'd3);

      // Instance C: N=8 M=3 MSB first, bits 1,0,1,0,1,0,0,0
      step();
      for (int b = 0; b < 8; b++) begin
         c_iv = 1'b1; c_in = (b == 0 || b == 2 || b == 4);
         @(negedge clk);
         chk($sformatf("C b%0d valid", b),   {31'd0, c_valid},   (b == 7) ? 32'd1 : 32'd0);
         chk($sformatf("C b%0d invalid", b), {31'd0, c_invalid}, 32'd0);
         step();
      end
      c_iv = 1'b0; c_in = 1'b0;
      @(negedge clk);
      chk("C word", {24'd0, c_word}, 32'hA8);
      chk("C wv",   {31'd0, c_wv},   32'd1);
      chk("C err",  {24'd0, c_err},  32'd0);
      $display("[TB] C word=%b", c_word);

      // Reset mid-word: three bits held, then reset with a strobed bit on the wire
      step();
      for (int b = 0; b < 3; b++) begin
         c_iv = 1'b1; c_in = 1'b1;
         step();
      end
      chk("C busy before reset", {31'd0, c_busy}, 32'd1);
      reset_l = 1'b0;
      #1;
      chk("C rst word",    {24'd0, c_word},    32'd0);
      chk("C rst wv",      {31'd0, c_wv},      32'd0);
      chk("C rst err",     {24'd0, c_err},     32'd0);
      chk("C rst busy",    {31'd0, c_busy},    32'd0);
      chk("C rst valid",   {31'd0, c_valid},   32'd0);
      chk("C rst invalid", {31'd0, c_invalid}, 32'd0);
      chk("A rst err",     {24'd0, a_err},     32'd0);
      chk("B rst err",     {30'd0, b_err},     32'd0);
      c_iv = 1'b0; c_in = 1'b0;
      step();
      reset_l = 1'b1;
      step();
      @(negedge clk);
      chk("C busy after reset", {31'd0, c_busy}, 32'd0);
      chk("C wv after reset",   {31'd0, c_wv},   32'd0);
      $display("[TB] reset mid-word checked");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
